gf_red_seq: RTL
===============

# gf_red_seq

Sequential, parametrised GF(2^m) polynomial reducer: it reduces a carry-less product of up to 2·DATA_WIDTH bits modulo a runtime-selected primitive polynomial of grade 2..DATA_WIDTH. It processes STEPS bit-positions per cycle behind a valid/ready handshake. It flags illegal grades instead of silently returning zero. It sits after the carry-less multiplier in the GF execution path and replaces the single-cycle combinational reducer where timing forbids a full W-deep XOR chain.

## Interface
- DATA_WIDTH, 12: maximum field grade W; result width.
- STEPS, 1: reduction steps (bit positions) retired per RUN cycle; 1..DATA_WIDTH.
- GRADE_W, $clog2(DATA_WIDTH+1): width of the grade port (must represent W).
- clk  in  1  clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- polyn_grade  in  GRADE_W  field grade m.
- polyn_red_in  in  W+1  primitive polynomial P; bit m is taken as 1; bits above m are ignored.
- reduc_in  in  2W  polynomial R to reduce; bits at or above 2m are ignored.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer ready.
- out  out  W  R mod P, zero-extended above bit m-1.
- out_err  out  1  the grade was illegal (m<2 or m>W).
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On accept, latch m, P masked to bits [m:0], R masked to bits [2m-1:0] into rem (2W bits), and j=2m-1.
  - Legal m → go to RUN.
  - Illegal m → go to DONE with out=0 and out_err=1.
- RUN: each cycle applies up to STEPS steps. One step at position j: if rem[j]=1, rem ^= P<<(j-m); then j=j-1. Stop after position m is processed (m steps total).
  - The last cycle may apply fewer than STEPS steps. Steps with j<m are no-ops.
  - After the final step → DONE.
  - The result is rem[m-1:0].
- DONE: out_valid=1, and out/out_err are stable.
  - On out_ready: go to IDLE.
  - In the same cycle, in_ready = out_ready. If in_valid is also high, the new request is latched and the next state is RUN (or DONE for an illegal grade). This gives back-to-back throughput with no IDLE bubble.
- Inputs are sampled only on an accepted cycle. Changes at any other time have no effect.
- All arithmetic is XOR (GF(2)); there are no carries.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1. out_valid=0, out=0, out_err=0, busy=0. State goes to IDLE, and rem and j are cleared.
- Let accept be at cycle t and N=ceil(m/STEPS). out_valid first becomes visible at t+N+1.
- Illegal grade: out_valid at t+1.
- Throughput: one result per N+1 cycles when out_ready is held high.
- rst asserted in any state, including mid-RUN or in DONE with a pending result, aborts the operation. The next cycle shows the reset values, and no result is emitted.
- out_valid may not drop and out may not change while out_valid=1 && out_ready=0.
- in_ready=0 in RUN, and in DONE when out_ready=0.

## Structure
- Shared package gf_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the constant GF_MIN_GRADE=2;
  - a grade-legality function reused by the other GF units.
- Sub-module gf_red_step: combinational. Inputs are rem, P, j and m; outputs are the next rem and next j for one step. Instantiate it STEPS times as a chain inside gf_red_seq. Each step XORs through the existing cl_add.

## Test plan
- W=8, STEPS=1, m=8, P=0x11B, R=0x2B79 → out=0xC1 and out_err=0. out_valid at t+9.
- W=8, STEPS=2, m=4, P=0x13, R=0xFF80 (bits at or above 8 ignored) → out=0xB. out_valid at t+3.
- W=8, m=1 and then m=9 → out=0, out_err=1, out_valid at t+1 for each.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE, toggling in_valid and the inputs → out stays stable and in_ready=0. Then raise out_ready with in_valid=1 → the new request is accepted in the same cycle and busy stays 1.
- Reset mid-RUN: m=8, assert rst at t+4 → next cycle has out_valid=0 and busy=0. A fresh request then completes correctly.
- Random: 10k requests with random m in 2..W, random P (bit m set), and random R, for STEPS ∈ {1,3,W} → out matches a reference model of polynomial modulo, and latency matches ceil(m/STEPS)+1.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions: FSM states, grade limits
// and the grade-legality check used by the GF units.
package gf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gf_state_e;

    localparam int GF_MIN_GRADE = 2;

    function automatic logic grade_ok(input int unsigned m, input int unsigned w);
        return (m >= GF_MIN_GRADE) && (m <= w);
    endfunction

endpackage

// File: rtl/cl_add.sv
// Carry-less (GF(2)) addition: bitwise XOR of two
// equal-width polynomials.
module cl_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/gf_red_step.sv
// One reduction step at bit position j: cancel rem[j] with
// P aligned to j, then move j down. No-op once j < m.
module gf_red_step #(
    parameter int W  = 8,
    parameter int JW = 4,
    parameter int GW = 4
) (
    input  logic [2*W-1:0] rem,
    input  logic [W:0]     p,
    input  logic [JW-1:0]  j,
    input  logic [GW-1:0]  m,
    output logic [2*W-1:0] rem_nxt,
    output logic [JW-1:0]  j_nxt
);

    logic [JW-1:0]  mj;
    logic [JW-1:0]  sh;
    logic           act;
    logic [2*W-1:0] addend;

    assign mj  = JW'(m);
    assign act = (j >= mj);
    assign sh  = j - mj;

    assign addend = (act && rem[j]) ? ({{(W-1){1'b0}}, p} << sh) : '0;

    cl_add #(.W(2*W)) u_add (
        .a (rem),
        .b (addend),
        .y (rem_nxt)
    );

    assign j_nxt = act ? j - JW'(1) : j;

endmodule

// File: rtl/gf_red_seq.sv
// Sequential GF(2^m) reducer: STEPS bit positions per cycle,
// valid/ready on both sides, flags illegal field grades.
module gf_red_seq
    import gf_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int STEPS      = 1,
    parameter int GRADE_W    = $clog2(DATA_WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [GRADE_W-1:0]      polyn_grade,
    input  logic [DATA_WIDTH:0]     polyn_red_in,
    input  logic [2*DATA_WIDTH-1:0] reduc_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    out_err,
    output logic                    busy
);

    localparam int W  = DATA_WIDTH;
    localparam int JW = $clog2(2 * W);

    gf_state_e state, state_nxt;

    logic [GRADE_W-1:0] m_q;
    logic [W:0]         p_q;
    logic [2*W-1:0]     rem;
    logic [JW-1:0]      j;
    logic               err;

    logic               accept;
    logic               legal;
    logic               run_end;
    logic [W:0]         p_mask;
    logic [2*W-1:0]     r_mask;
    logic [JW-1:0]      j_init;

    logic [2*W-1:0]     rem_c [STEPS+1];
    logic [JW-1:0]      j_c   [STEPS+1];

    assign legal  = grade_ok(int'(polyn_grade), W);
    assign accept = in_valid && in_ready;
    assign j_init = JW'(2 * int'(polyn_grade) - 1);

    // Bit m of P is implied; nothing at or above 2m of R takes part.
    always_comb begin
        p_mask = '0;
        r_mask = '0;
        for (int i = 0; i <= W; i++)
            p_mask[i] = (i < int'(polyn_grade)) ? polyn_red_in[i]
                                                : (i == int'(polyn_grade));
        for (int i = 0; i < 2 * W; i++)
            r_mask[i] = (i < 2 * int'(polyn_grade)) ? reduc_in[i] : 1'b0;
    end

    assign rem_c[0] = rem;
    assign j_c[0]   = j;

    for (genvar s = 0; s < STEPS; s++) begin : g_step
        gf_red_step #(.W(W), .JW(JW), .GW(GRADE_W)) u_step (
            .rem     (rem_c[s]),
            .p       (p_q),
            .j       (j_c[s]),
            .m       (m_q),
            .rem_nxt (rem_c[s+1]),
            .j_nxt   (j_c[s+1])
        );
    end

    assign run_end = (j_c[STEPS] < JW'(m_q));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = legal ? RUN : DONE;
            RUN:  if (run_end) state_nxt = DONE;
            DONE: begin
                if (out_ready)
                    state_nxt = accept ? (legal ? RUN : DONE) : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q <= '0;
            p_q <= '0;
            rem <= '0;
            j   <= '0;
            err <= 1'b0;
        end else if (accept) begin
            m_q <= polyn_grade;
            p_q <= legal ? p_mask : '0;
            rem <= legal ? r_mask : '0;
            j   <= legal ? j_init : '0;
            err <= !legal;
        end else if (state == RUN) begin
            rem <= rem_c[STEPS];
            j   <= j_c[STEPS];
        end
    end

    // Bits m and above are already cleared once reduction finishes.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out       = '0;
        out_err   = 1'b0;
        busy      = (state != IDLE);
        if (!rst)
            in_ready = (state == IDLE) || (state == DONE && out_ready);
        if (state == DONE) begin
            out_valid = 1'b1;
            out       = rem[W-1:0];
            out_err   = err;
        end
    end

endmodule
